// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit for the MiniALU datapath.
// One instruction at a time over valid/ready. Single-cycle ALU ops retire one
// cycle after accept. MUL runs a DATA_W-step shift-add loop.
module cu_multicycle #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int INSTR_W  = 3 + 3*ADDR_W + DATA_W
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [INSTR_W-1:0]           INSTRUCTION,
  input  logic                         INSTR_VALID,
  output logic                         INSTR_READY,
  output logic                         DONE,
  output logic                         FLAG_ZERO,
  output logic                         FLAG_CARRY,
  output logic [NUM_REGS*DATA_W-1:0]   REGISTER_OUTPUT_DATA_BUS
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADI = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t r_state;
  state_t w_state_next;

  // Instruction fields, MSB first: opcode, dst, src1, src2, imm
  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_dst;
  logic [ADDR_W-1:0] w_src1;
  logic [ADDR_W-1:0] w_src2;
  logic [DATA_W-1:0] w_imm;

  assign w_op   = INSTRUCTION[INSTR_W-1 -: 3];
  assign w_dst  = INSTRUCTION[DATA_W+3*ADDR_W-1 -: ADDR_W];
  assign w_src1 = INSTRUCTION[DATA_W+2*ADDR_W-1 -: ADDR_W];
  assign w_src2 = INSTRUCTION[DATA_W+ADDR_W-1 -: ADDR_W];
  assign w_imm  = INSTRUCTION[DATA_W-1:0];

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_imm;
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_zero;
  logic                r_carry;

  logic                w_accept;
  logic                w_wb;
  logic                w_retire;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_acc_step;
  logic [DATA_W-1:0]   w_result;
  logic                w_carry;

  // State register; reset returns to IDLE and aborts any instruction in flight
  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state, accept, writeback and retire decisions
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wb         = 1'b0;
    w_retire     = 1'b0;
    INSTR_READY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          w_accept     = 1'b1;
          w_state_next = (w_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_IDLE;
        w_retire     = 1'b1;
        w_wb         = (r_op != OP_NOP);
      end
      S_MUL: begin
        // The step taken while the counter reads 1 is the last one
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_IDLE;
          w_retire     = 1'b1;
          w_wb         = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result and carry for the op being retired (MUL uses the final step's sum)
  always_comb begin
    w_sum      = {1'b0, r_a} + {1'b0, r_b};
    w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_result   = '0;
    w_carry    = 1'b0;
    case (r_op)
      OP_LOADI: w_result = r_imm;
      OP_ADD: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_result = r_a - r_b;
        w_carry  = (r_a < r_b);
      end
      OP_MUL: begin
        w_result = w_acc_step[DATA_W-1:0];
        w_carry  = |w_acc_step[2*DATA_W-1:DATA_W];
      end
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      default: w_result = '0;
    endcase
  end

  // Operand latch, multiply iteration, register-file writeback and flags
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_op     <= OP_NOP;
      r_dst    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_done <= w_retire;
      if (w_accept) begin
        // Source values are captured here, so dst==src uses the old contents
        r_op     <= w_op;
        r_dst    <= w_dst;
        r_a      <= r_regs[w_src1];
        r_b      <= r_regs[w_src2];
        r_imm    <= w_imm;
        r_acc    <= '0;
        r_mcand  <= {{DATA_W{1'b0}}, r_regs[w_src1]};
        r_mplier <= r_regs[w_src2];
        r_cnt    <= (w_op == OP_MUL) ? CNT_W'(DATA_W) : '0;
      end
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_step;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
      end
      if (w_wb) begin
        r_regs[r_dst] <= w_result;
        r_zero        <= (w_result == '0);
        r_carry       <= w_carry;
      end
    end
  end

  assign DONE       = r_done;
  assign FLAG_ZERO  = r_zero;
  assign FLAG_CARRY = r_carry;

  // Flatten the register file: register gi occupies bits [gi*DATA_W +: DATA_W]
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bus
      assign REGISTER_OUTPUT_DATA_BUS[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cu_multicycle.sv
// Self-checking bench for cu_multicycle (default 32x4 instance plus an 8x8 instance).
module tb_cu_multicycle;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int IW = 3 + 3*AW + W;

  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         MUL = 3'd4, AND = 3'd5, ORR = 3'd6, XOR = 3'd7;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [IW-1:0] INSTRUCTION;
  logic          INSTR_VALID;
  logic          INSTR_READY, DONE, FLAG_ZERO, FLAG_CARRY;
  logic [N*W-1:0] BUS;

  logic          RESET_N8;
  logic [19:0]   INSTR8;
  logic          VALID8;
  logic          READY8, DONE8, FZ8, FC8;
  logic [63:0]   BUS8;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  cu_multicycle #(.DATA_W(W), .NUM_REGS(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .DONE(DONE), .FLAG_ZERO(FLAG_ZERO), .FLAG_CARRY(FLAG_CARRY),
    .REGISTER_OUTPUT_DATA_BUS(BUS));

  cu_multicycle #(.DATA_W(8), .NUM_REGS(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N8), .INSTRUCTION(INSTR8), .INSTR_VALID(VALID8),
    .INSTR_READY(READY8), .DONE(DONE8), .FLAG_ZERO(FZ8), .FLAG_CARRY(FC8),
    .REGISTER_OUTPUT_DATA_BUS(BUS8));

  typedef struct {
    logic [N*W-1:0] bus;
    logic           z;
    logic           c;
    int             acc;
    int             lat;
  } exp_t;

  exp_t        sb[$];
  logic [W-1:0] m_regs [N];
  logic         m_z, m_c;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [IW-1:0] mk(logic [2:0] op, int d, int s1, int s2, logic [W-1:0] imm);
    return {op, AW'(d), AW'(s1), AW'(s2), imm};
  endfunction

  function automatic logic [N*W-1:0] model_bus();
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = m_regs[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
    sb.delete();
  endtask

  // Waits for READY, lets the accept edge pass, then pushes the model's expectation
  task automatic accept_now(input logic [2:0] op, input int d, input int s1, input int s2,
                            input logic [W-1:0] imm, output int acc_cyc);
    int n = 0;
    logic [W-1:0] a, b, res;
    logic [W:0] s;
    logic [2*W-1:0] p;
    logic c;
    exp_t e;
    while (!INSTR_READY && n < 200) begin @(negedge CLK); n++; end
    if (!INSTR_READY) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: READY=%b required 1", INSTR_READY);
      acc_cyc = -1000;
      return;
    end
    @(posedge CLK); #1;
    acc_cyc = cyc;
    a = m_regs[s1]; b = m_regs[s2]; res = '0; c = 1'b0;
    case (op)
      LDI: res = imm;
      ADD: begin s = {1'b0, a} + {1'b0, b}; res = s[W-1:0]; c = s[W]; end
      SUB: begin res = a - b; c = (a < b); end
      MUL: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; res = p[W-1:0]; c = (p[2*W-1:W] != 0); end
      AND: res = a & b;
      ORR: res = a | b;
      XOR: res = a ^ b;
      default: res = '0;
    endcase
    if (op != NOP) begin
      m_regs[d] = res;
      m_z = (res == '0);
      m_c = c;
    end
    e.bus = model_bus(); e.z = m_z; e.c = m_c; e.acc = acc_cyc;
    e.lat = (op == MUL) ? W : 1;
    sb.push_back(e);
  endtask

  // Waits for DONE and checks it against the oldest scoreboard entry
  task automatic wait_retire(input string tag);
    exp_t e;
    int n = 0;
    while (!DONE && n < 100) begin @(negedge CLK); n++; end
    n_cmp++;
    if (!DONE) begin n_bad++; $display("FAIL %s_done_timeout: DONE=0 required 1", tag); return; end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL %s_unexpected_done: queue empty", tag); return; end
    e = sb.pop_front();
    n_cmp++;
    if (BUS !== e.bus) begin n_bad++; $display("FAIL %s_bus: got %h required %h", tag, BUS, e.bus); end
    n_cmp++;
    if (FLAG_ZERO !== e.z) begin n_bad++; $display("FAIL %s_zero: got %b required %b", tag, FLAG_ZERO, e.z); end
    n_cmp++;
    if (FLAG_CARRY !== e.c) begin n_bad++; $display("FAIL %s_carry: got %b required %b", tag, FLAG_CARRY, e.c); end
    n_cmp++;
    if (cyc - e.acc !== e.lat) begin n_bad++; $display("FAIL %s_latency: got %0d required %0d", tag, cyc - e.acc, e.lat); end
    n_cmp++;
    if (INSTR_READY !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after: got %b required 1", tag, INSTR_READY); end
    $display("retire %s: bus=%h Z=%b C=%b", tag, BUS, FLAG_ZERO, FLAG_CARRY);
  endtask

  task automatic issue(input logic [2:0] op, input int d, input int s1, input int s2,
                       input logic [W-1:0] imm, input string tag);
    int acc;
    INSTRUCTION = mk(op, d, s1, s2, imm);
    INSTR_VALID = 1'b1;
    accept_now(op, d, s1, s2, imm, acc);
    INSTR_VALID = 1'b0;
    wait_retire(tag);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RESET_N8 = 1'b0; VALID8 = 1'b0; INSTR8 = '0;
    INSTRUCTION = mk(LDI, 1, 0, 0, 32'h55); INSTR_VALID = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    n_cmp++; if (BUS !== '0) begin n_bad++; $display("FAIL reset_bus: got %h required 0", BUS); end
    n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", DONE); end
    n_cmp++; if ({FLAG_ZERO, FLAG_CARRY} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b required 00", {FLAG_ZERO, FLAG_CARRY}); end
    n_cmp++; if (INSTR_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", INSTR_READY); end
    RESET_N = 1'b1; RESET_N8 = 1'b1; INSTR_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (DONE !== 1'b0 || BUS !== '0) begin n_bad++; $display("FAIL reset_no_accept: DONE=%b bus=%h required 0/0", DONE, BUS); end
    $display("reset: bus=%h READY=%b", BUS, INSTR_READY);
  endtask

  task automatic test_arith();
    issue(LDI, 1, 0, 0, 32'h0000000C, "loadi_r1");
    issue(LDI, 2, 0, 0, 32'h00000006, "loadi_r2");
    n_cmp++; if (BUS[63:32] !== 32'h0000000C || BUS[95:64] !== 32'h00000006) begin
      n_bad++; $display("FAIL loadi_slices: got %h/%h required 0000000c/00000006", BUS[63:32], BUS[95:64]); end
    issue(ADD, 3, 1, 2, 0, "add_r3");
    issue(SUB, 0, 2, 1, 0, "sub_r0");
    issue(NOP, 3, 0, 0, 32'hDEAD, "nop");
  endtask

  task automatic test_mul();
    int acc, low;
    INSTRUCTION = mk(MUL, 3, 1, 2, 0); INSTR_VALID = 1'b1;
    accept_now(MUL, 3, 1, 2, 0, acc);
    INSTR_VALID = 1'b0;
    low = 0;
    @(negedge CLK);
    while (!INSTR_READY && low < 100) begin low++; @(negedge CLK); end
    n_cmp++; if (low !== W) begin n_bad++; $display("FAIL mul_ready_low: got %0d cycles required %0d", low, W); end
    wait_retire("mul_12x6");
    issue(LDI, 1, 0, 0, 32'hFFFFFFFF, "loadi_ffff");
    issue(LDI, 2, 0, 0, 32'h00000001, "loadi_one");
    issue(ADD, 3, 1, 2, 0, "add_wrap");
    issue(LDI, 2, 0, 0, 32'h00000002, "loadi_two");
    issue(MUL, 0, 1, 2, 0, "mul_ovf");
  endtask

  task automatic test_random();
    logic [2:0] ops [6];
    ops[0] = ADD; ops[1] = SUB; ops[2] = AND; ops[3] = ORR; ops[4] = XOR; ops[5] = MUL;
    for (int i = 0; i < N; i++) issue(LDI, i, 0, 0, $urandom, "rnd_load");
    for (int i = 0; i < 12; i++)
      issue(ops[i % 6], $urandom_range(N-1), $urandom_range(N-1), $urandom_range(N-1), $urandom, "rnd_op");
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b;
    INSTRUCTION = mk(LDI, 2, 0, 0, 32'h5A5A); INSTR_VALID = 1'b1;
    accept_now(LDI, 2, 0, 0, 32'h5A5A, acc_a);
    INSTRUCTION = mk(XOR, 1, 1, 1, 0);
    wait_retire("b2b_first");
    accept_now(XOR, 1, 1, 1, 0, acc_b);
    INSTR_VALID = 1'b0;
    n_cmp++; if (acc_b - acc_a !== 2) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d required 2", acc_b - acc_a); end
    @(negedge CLK);
    n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_done: got %b required 0", DONE); end
    wait_retire("b2b_xor");
    @(negedge CLK);
    n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width: got %b required 0", DONE); end
  endtask

  task automatic test_reset_abort();
    int acc, seen;
    issue(LDI, 1, 0, 0, 32'h0000000C, "abort_load1");
    issue(LDI, 2, 0, 0, 32'h00000006, "abort_load2");
    INSTRUCTION = mk(MUL, 3, 1, 2, 0); INSTR_VALID = 1'b1;
    accept_now(MUL, 3, 1, 2, 0, acc);
    INSTR_VALID = 1'b0;
    repeat (9) @(negedge CLK);
    RESET_N = 1'b0;
    INSTRUCTION = mk(LDI, 0, 0, 0, 32'h77); INSTR_VALID = 1'b1;
    @(negedge CLK);
    n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b required 0", DONE); end
    n_cmp++; if (BUS !== '0) begin n_bad++; $display("FAIL abort_bus: got %h required 0", BUS); end
    n_cmp++; if (INSTR_READY !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b required 1", INSTR_READY); end
    @(negedge CLK);
    RESET_N = 1'b1; INSTR_VALID = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge CLK); if (DONE) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses required 0", seen); end
    n_cmp++; if (BUS !== '0 || {FLAG_ZERO, FLAG_CARRY} !== 2'b00) begin
      n_bad++; $display("FAIL abort_state: bus=%h flags=%b required 0/00", BUS, {FLAG_ZERO, FLAG_CARRY}); end
    $display("abort: bus=%h READY=%b done_pulses=%0d", BUS, INSTR_READY, seen);
  endtask

  // Sends one instruction to the 8-bit instance and returns its latency (-1 on timeout)
  task automatic send8(input logic [19:0] ins, output int lat);
    int n = 0, acc;
    INSTR8 = ins; VALID8 = 1'b1;
    while (!READY8 && n < 100) begin @(negedge CLK); n++; end
    @(posedge CLK); #1;
    acc = cyc; VALID8 = 1'b0; n = 0;
    while (!DONE8 && n < 100) begin @(negedge CLK); n++; end
    lat = DONE8 ? (cyc - acc) : -1;
  endtask

  task automatic test_param8();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [15:0] p;
    int lat;
    av[0] = 8'hFF; bv[0] = 8'hFF;
    av[1] = 8'h0F; bv[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      send8({LDI, 3'd5, 3'd0, 3'd0, av[i]}, lat);
      send8({LDI, 3'd6, 3'd0, 3'd0, bv[i]}, lat);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL p8_load_latency: got %0d required 1", lat); end
      send8({MUL, 3'd7, 3'd5, 3'd6, 8'h00}, lat);
      p = {8'h00, av[i]} * {8'h00, bv[i]};
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL p8_mul_latency: got %0d required 8", lat); end
      n_cmp++; if (BUS8[56 +: 8] !== p[7:0]) begin n_bad++; $display("FAIL p8_mul_result: got %h required %h", BUS8[56 +: 8], p[7:0]); end
      n_cmp++; if (FC8 !== (p[15:8] != 0)) begin n_bad++; $display("FAIL p8_mul_carry: got %b required %b", FC8, (p[15:8] != 0)); end
      n_cmp++; if (BUS8[40 +: 16] !== {bv[i], av[i]}) begin n_bad++; $display("FAIL p8_operands: got %h required %h", BUS8[40 +: 16], {bv[i], av[i]}); end
      $display("param8 %h*%h: r7=%h C=%b lat=%0d", av[i], bv[i], BUS8[56 +: 8], FC8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_param8();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
